// File: rtl/register_write_demux_32_bit.sv
// 32 x 32-bit register file with a 5-to-32 write decoder; reads are combinational (0 cycles), the write lands on the rising edge.
// No backpressure: every accepted write is committed on the edge, and write_onehot/write_count report it one cycle later.
module register_write_demux_32_bit #(
    parameter int BYPASS    = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic [4:0]           write_addr,
    input  logic [31:0]          write_data,
    input  logic [4:0]           read_addr_1,
    input  logic [4:0]           read_addr_2,
    output logic [31:0]          read_data_1,
    output logic [31:0]          read_data_2,
    output logic [31:0]          write_onehot,
    output logic [CNT_WIDTH-1:0] write_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [31:0] regs [32];
    logic [31:0] sel;

    // Bit 0 is never decoded, so $zero can never be written or flagged.
    always_comb begin
        sel = '0;
        for (int n = 1; n < 32; n++) begin
            sel[n] = write_enable & (write_addr == 5'(n));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 32; n++) begin
                regs[n] <= '0;
            end
            write_onehot <= '0;
            write_count  <= '0;
        end else begin
            for (int n = 1; n < 32; n++) begin
                if (sel[n]) begin
                    regs[n] <= write_data;
                end
            end
            write_onehot <= sel;
            if ((|sel) && (write_count != CNT_MAX)) begin
                write_count <= write_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        if (read_addr_1 == 5'd0) begin
            read_data_1 = '0;
        end else if ((BYPASS != 0) && sel[read_addr_1]) begin
            read_data_1 = write_data;
        end else begin
            read_data_1 = regs[read_addr_1];
        end
    end

    always_comb begin
        if (read_addr_2 == 5'd0) begin
            read_data_2 = '0;
        end else if ((BYPASS != 0) && sel[read_addr_2]) begin
            read_data_2 = write_data;
        end else begin
            read_data_2 = regs[read_addr_2];
        end
    end

endmodule

// File: tb/tb_register_write_demux_32_bit.sv
// Directed scoreboard bench: dut_a has bypass and a 4-bit counter, dut_b has no bypass and a 16-bit counter.
module tb_register_write_demux_32_bit;

    logic        clock;
    logic        reset;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr_1;
    logic [4:0]  read_addr_2;

    logic [31:0] rd1_a, rd2_a, oh_a;
    logic [3:0]  cnt_a;
    logic [31:0] rd1_b, rd2_b, oh_b;
    logic [15:0] cnt_b;

    register_write_demux_32_bit #(.BYPASS(1), .CNT_WIDTH(4)) dut_a (
        .clock(clock), .reset(reset), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data),
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(rd1_a), .read_data_2(rd2_a),
        .write_onehot(oh_a), .write_count(cnt_a)
    );

    register_write_demux_32_bit #(.BYPASS(0), .CNT_WIDTH(16)) dut_b (
        .clock(clock), .reset(reset), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data),
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(rd1_b), .read_data_2(rd2_b),
        .write_onehot(oh_b), .write_count(cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] rd1a, rd2a, rd1b, rd2b, oh;
        int          cnta, cntb;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s.%s got %h expected %h", name, field, act, req);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, after the inputs of this cycle have settled.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "rd1_a", rd1_a, e.rd1a);
            cmp(e.name, "rd2_a", rd2_a, e.rd2a);
            cmp(e.name, "rd1_b", rd1_b, e.rd1b);
            cmp(e.name, "rd2_b", rd2_b, e.rd2b);
            cmp(e.name, "oh_a", oh_a, e.oh);
            cmp(e.name, "oh_b", oh_b, e.oh);
            cmp(e.name, "cnt_a", 32'(cnt_a), 32'(e.cnta));
            cmp(e.name, "cnt_b", 32'(cnt_b), 32'(e.cntb));
        end
    end

    task automatic vec(input string name, input bit chk,
                       input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [31:0] e_rd1a, input logic [31:0] e_rd2a,
                       input logic [31:0] e_rd1b, input logic [31:0] e_rd2b,
                       input logic [31:0] e_oh, input int e_cnta, input int e_cntb);
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rst;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr_1  = ra1;
        read_addr_2  = ra2;
        if (chk) begin
            e.name = name;
            e.rd1a = e_rd1a; e.rd2a = e_rd2a;
            e.rd1b = e_rd1b; e.rd2b = e_rd2b;
            e.oh   = e_oh;
            e.cnta = e_cnta; e.cntb = e_cntb;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        reset        = 1'b1;
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        read_addr_1  = '0;
        read_addr_2  = '0;

        //   name           chk rst we wa  wd             ra1 ra2  rd1a           rd2a           rd1b           rd2b           onehot         ca  cb
        vec("reset",        0, 1, 0, 0,  32'h0,         0,  0,   32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0,  0);
        vec("after_reset",  1, 0, 0, 0,  32'h0,         8,  31,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0,  0);
        vec("wr8",          1, 0, 1, 8,  32'hDEADBEEF,  8,  0,   32'hDEADBEEF,  32'h0,         32'h0,         32'h0,         32'h0,         0,  0);
        vec("rd8",          1, 0, 0, 0,  32'h0,         8,  0,   32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'h0,         32'h0000_0100, 1,  1);
        vec("wr0",          1, 0, 1, 0,  32'hFFFFFFFF,  0,  8,   32'h0,         32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'h0,         1,  1);
        vec("rd0",          1, 0, 0, 0,  32'h0,         0,  8,   32'h0,         32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'h0,         1,  1);
        vec("wr31_byp",     1, 0, 1, 31, 32'h12345678,  31, 31,  32'h12345678,  32'h12345678,  32'h0,         32'h0,         32'h0,         1,  1);
        vec("we0_addr5",    1, 0, 0, 5,  32'hAAAA5555,  31, 5,   32'h12345678,  32'h0,         32'h12345678,  32'h0,         32'h8000_0000, 2,  2);
        vec("rd5_unchg",    1, 0, 0, 0,  32'h0,         5,  31,  32'h0,         32'h12345678,  32'h0,         32'h12345678,  32'h0,         2,  2);
        vec("wr3",          1, 0, 1, 3,  32'h3,         3,  8,   32'h3,         32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'h0,         2,  2);
        vec("wr4",          1, 0, 1, 4,  32'h4,         3,  4,   32'h3,         32'h4,         32'h3,         32'h0,         32'h0000_0008, 3,  3);

        // Back-to-back writes to regs 10..23 drive dut_a's 4-bit counter into saturation.
        for (int j = 0; j < 14; j++) begin
            logic [31:0] d;
            logic [31:0] oh;
            d  = 32'hC0DE_0000 + 32'(j);
            oh = (j == 0) ? 32'h0000_0010 : (32'h1 << (9 + j));
            vec($sformatf("sat%0d", j), 1, 0, 1, 5'(10 + j), d, 5'(10 + j), 0,
                d, 32'h0, 32'h0, 32'h0, oh, (4 + j > 15) ? 15 : 4 + j, 4 + j);
        end

        vec("wr24",         1, 0, 1, 24, 32'h24,        10, 23,  32'hC0DE0000,  32'hC0DE000D,  32'hC0DE0000,  32'hC0DE000D,  32'h0080_0000, 15, 18);
        vec("rst_with_wr",  1, 1, 1, 25, 32'h55,        24, 24,  32'h24,        32'h24,        32'h24,        32'h24,        32'h0100_0000, 15, 19);
        vec("post_reset",   1, 0, 0, 0,  32'h0,         25, 24,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0,  0);
        vec("wr25",         1, 0, 1, 25, 32'h99,        25, 10,  32'h99,        32'h0,         32'h0,         32'h0,         32'h0,         0,  0);
        vec("rd25_both",    1, 0, 0, 0,  32'h0,         25, 25,  32'h99,        32'h99,        32'h99,        32'h99,        32'h0200_0000, 1,  1);

        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clock);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL drain pending %0d expected 0", exp_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
